// File: rtl/scope_pkg.sv
// Shared constants, state encoding and trigger compare for the capture writer.
package scope_pkg;

  localparam int SAMPLE_W = 8;
  localparam int LANES    = 15;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = SAMPLE_W * LANES;
  localparam int LANE_W   = 4;

  typedef logic [2:0] capture_state_t;

  localparam capture_state_t ST_IDLE      = 3'd0;
  localparam capture_state_t ST_PRETRIG   = 3'd1;
  localparam capture_state_t ST_WAIT_TRIG = 3'd2;
  localparam capture_state_t ST_POST      = 3'd3;
  localparam capture_state_t ST_DONE      = 3'd4;

  // Level crossing between two consecutive samples, in the armed direction.
  function automatic logic trig_compare(
    input logic [SAMPLE_W-1:0] prev,
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] level,
    input logic                rising
  );
    if (rising) return (prev < level) && (cur >= level);
    else        return (prev > level) && (cur <= level);
  endfunction

endpackage

// File: rtl/scope_capture_writer_if.sv
// Sample stream in, capture-RAM write port out.
interface scope_capture_writer_if #(
  parameter int SAMPLE_W = scope_pkg::SAMPLE_W,
  parameter int ADDR_W   = scope_pkg::ADDR_W,
  parameter int DATA_W   = scope_pkg::DATA_W
);

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                ram_ce;
  logic                ram_wre;
  logic [ADDR_W-1:0]   ram_ad;
  logic [DATA_W-1:0]   ram_din;

  modport master (
    input  sample_valid, sample,
    output ram_ce, ram_wre, ram_ad, ram_din
  );

  modport slave (
    output sample_valid, sample,
    input  ram_ce, ram_wre, ram_ad, ram_din
  );

endinterface

// File: rtl/scope_capture_writer_trig_detect.sv
// Previous-sample register plus level/edge compare; hit is combinational on the
// current accepted sample.
module trig_detect
  import scope_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                accept,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                rising,
  output logic                hit
);

  logic [SAMPLE_W-1:0] prev;
  logic                prev_valid;

  assign hit = accept && prev_valid && trig_compare(prev, sample, level, rising);

  // NOTE: non-blocking updates keep the compare above looking at the pre-edge prev.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (accept) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/scope_capture_writer.sv
// Capture writer: packs samples into RAM words, runs the pretrigger/trigger/post
// sequence and freezes the circular buffer with the trigger position.
module scope_capture_writer #(
  parameter int SAMPLE_W = scope_pkg::SAMPLE_W,
  parameter int LANES    = scope_pkg::LANES,
  parameter int ADDR_W   = scope_pkg::ADDR_W,
  parameter int DATA_W   = SAMPLE_W * LANES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          abort,
  input  logic [SAMPLE_W-1:0]           trig_level,
  input  logic                          trig_rising,
  input  logic [ADDR_W-1:0]             pretrig_words,
  scope_capture_writer_if.master        bus,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W-1:0]             trig_addr,
  output logic [scope_pkg::LANE_W-1:0]  trig_lane
);

  import scope_pkg::*;

  localparam logic [ADDR_W:0]     DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);

  capture_state_t                 state;
  logic [LANE_W-1:0]              lane_cnt;
  logic [LANES-2:0][SAMPLE_W-1:0] pack;
  logic [ADDR_W-1:0]              word_ad;
  logic [ADDR_W-1:0]              word_cnt;
  logic [ADDR_W:0]                post_cnt;
  logic [ADDR_W:0]                post_load;

  logic [SAMPLE_W-1:0]            cfg_level;
  logic                           cfg_rising;
  logic [ADDR_W-1:0]              cfg_pretrig;

  logic                           ram_wre_q;
  logic [ADDR_W-1:0]              ram_ad_q;
  logic [DATA_W-1:0]              ram_din_q;
  logic [ADDR_W-1:0]              trig_addr_q;
  logic [LANE_W-1:0]              trig_lane_q;

  logic                           capturing;
  logic                           accept;
  logic                           arm_take;
  logic                           word_done;
  logic                           hit;
  logic                           trig_fire;

  assign capturing = (state == ST_PRETRIG) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  assign accept    = bus.sample_valid && capturing && !abort;
  assign arm_take  = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign word_done = accept && (lane_cnt == LAST_LANE);
  assign trig_fire = hit && (state == ST_WAIT_TRIG);
  assign post_load = DEPTH - {1'b0, cfg_pretrig};

  assign bus.ram_ce  = ram_wre_q;
  assign bus.ram_wre = ram_wre_q;
  assign bus.ram_ad  = ram_ad_q;
  assign bus.ram_din = ram_din_q;
  assign busy        = capturing;
  assign done        = (state == ST_DONE);
  assign trig_addr   = trig_addr_q;
  assign trig_lane   = trig_lane_q;

  trig_detect u_trig_detect (
    .clk    (clk),
    .reset  (reset),
    .clear  (arm_take || abort),
    .accept (accept),
    .sample (bus.sample),
    .level  (cfg_level),
    .rising (cfg_rising),
    .hit    (hit)
  );

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state       <= ST_IDLE;
      lane_cnt    <= '0;
      // NOTE: pack is datapath-only, but clearing it keeps a discarded partial word out of ram_din.
      pack        <= '0;
      word_ad     <= '0;
      word_cnt    <= '0;
      post_cnt    <= '0;
      cfg_level   <= '0;
      cfg_rising  <= 1'b0;
      cfg_pretrig <= '0;
      ram_wre_q   <= 1'b0;
      ram_ad_q    <= '0;
      ram_din_q   <= '0;
      trig_addr_q <= '0;
      trig_lane_q <= '0;
    end else begin
      ram_wre_q <= 1'b0;

      if (accept) begin
        if (word_done) begin
          ram_din_q <= {bus.sample, pack};
          ram_ad_q  <= word_ad;
          ram_wre_q <= 1'b1;
          word_ad   <= word_ad + 1'b1;
          lane_cnt  <= '0;
        end else begin
          pack[lane_cnt] <= bus.sample;
          lane_cnt       <= lane_cnt + 1'b1;
        end
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm_take) begin
            cfg_level   <= trig_level;
            cfg_rising  <= trig_rising;
            cfg_pretrig <= pretrig_words;
            lane_cnt    <= '0;
            word_ad     <= '0;
            word_cnt    <= '0;
            trig_addr_q <= '0;
            trig_lane_q <= '0;
            state       <= (pretrig_words == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
          end
        end
        ST_PRETRIG: begin
          if (word_done) begin
            word_cnt <= word_cnt + 1'b1;
            if (ADDR_W'(word_cnt + 1'b1) == cfg_pretrig) state <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (trig_fire) begin
            trig_addr_q <= word_ad;
            trig_lane_q <= lane_cnt;
            // A lane-14 trigger sample completes its word now, so that write counts already.
            post_cnt    <= word_done ? post_load - 1'b1 : post_load;
            state       <= ST_POST;
          end
        end
        ST_POST: begin
          // Leaving one edge after the final write puts done the cycle after ram_wre.
          if (post_cnt == '0)  state    <= ST_DONE;
          else if (word_done)  post_cnt <= post_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scope_capture_writer.sv
// Directed bench for scope_capture_writer: a packing model queues expected RAM
// writes while a negedge monitor pops and compares every ram_wre strobe.
module tb_scope_capture_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        abort;
  logic [7:0]  trig_level;
  logic        trig_rising;
  logic [7:0]  pretrig_words;
  logic        busy;
  logic        done;
  logic [7:0]  trig_addr;
  logic [3:0]  trig_lane;

  scope_capture_writer_if bus ();

  scope_capture_writer dut (
    .clk           (clk),
    .reset         (reset),
    .arm           (arm),
    .abort         (abort),
    .trig_level    (trig_level),
    .trig_rising   (trig_rising),
    .pretrig_words (pretrig_words),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .trig_addr     (trig_addr),
    .trig_lane     (trig_lane)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   ad;
    logic [119:0] din;
  } wr_t;

  wr_t          exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_writes = 0;
  int           cyc = 0;
  int           last_wre_cyc = -10;
  int           done_rise_cyc = -10;
  logic         done_q = 1'b0;
  logic [7:0]   m_addr;
  int           m_lane;
  logic [119:0] m_word;
  int           w0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    check("ram_ce_eq_wre", bus.ram_ce, bus.ram_wre);
    if (bus.ram_wre === 1'b1) begin
      n_writes++;
      last_wre_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got ad=%0h din=%0h, expected no write", bus.ram_ad, bus.ram_din);
      end else begin
        e = exp_q.pop_front();
        check("ram_ad", bus.ram_ad, e.ad);
        check("ram_din", bus.ram_din, e.din);
      end
    end
    if (done === 1'b1 && done_q !== 1'b1) done_rise_cyc = cyc;
    done_q = done;
  end

  task automatic send(input logic [7:0] s, input bit cap);
    bus.sample_valid = 1'b1;
    bus.sample       = s;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    if (cap) begin
      m_word[8*m_lane +: 8] = s;
      if (m_lane == 14) begin
        exp_q.push_back('{m_addr, m_word});
        m_addr++;
        m_lane = 0;
      end else begin
        m_lane++;
      end
    end
  endtask

  task automatic do_arm(input logic [7:0] lvl, input logic rise, input logic [7:0] pre,
                        input logic sv, input logic [7:0] s);
    arm              = 1'b1;
    trig_level       = lvl;
    trig_rising      = rise;
    pretrig_words    = pre;
    bus.sample_valid = sv;
    bus.sample       = s;
    @(posedge clk); #1;
    arm              = 1'b0;
    bus.sample_valid = 1'b0;
    m_lane = 0;
    m_addr = '0;
    m_word = '0;
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk); #1;
    check({name, "_ram_wre"},   bus.ram_wre, 0);
    check({name, "_ram_ce"},    bus.ram_ce,  0);
    check({name, "_busy"},      busy,        0);
    check({name, "_done"},      done,        0);
    check({name, "_ram_ad"},    bus.ram_ad,  0);
    check({name, "_ram_din"},   bus.ram_din, 0);
    check({name, "_trig_addr"}, trig_addr,   0);
    check({name, "_trig_lane"}, trig_lane,   0);
  endtask

  task automatic wait_done(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      seen = done;
    end
    check({name, "_done_seen"}, seen, 1);
    if (seen) check({name, "_done_after_last_wre"}, done_rise_cyc - last_wre_cyc, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0;
    trig_level = '0; trig_rising = 1'b0; pretrig_words = '0;
    bus.sample_valid = 1'b0; bus.sample = '0;
    m_lane = 0; m_addr = '0; m_word = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs("reset");

    // Ramp, pretrig 16, rising through 100: the crossing is 99->100 at sample 356
    // (word 23, lane 11); 23 words before it plus 240 post words = 263 writes.
    w0 = n_writes;
    do_arm(8'd100, 1'b1, 8'd16, 1'b0, 8'd0);
    check("ramp_busy_after_arm", busy, 1);
    for (int i = 0; i < 263 * 15; i++) send(8'(i), 1'b1);
    wait_done("ramp");
    check("ramp_trig_addr", trig_addr, 23);
    check("ramp_trig_lane", trig_lane, 11);
    check("ramp_writes", n_writes - w0, 263);
    check("ramp_busy_done", busy, 0);
    for (int i = 0; i < 30; i++) send(8'(i), 1'b0);
    check("ramp_no_write_in_done", n_writes - w0, 263);
    check("ramp_trig_hold", trig_addr, 23);
    check("ramp_queue_empty", exp_q.size(), 0);

    // 10,200 repeating, falling through 50, no pretrigger: fires on sample 2.
    w0 = n_writes;
    do_arm(8'd50, 1'b0, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 256 * 15; i++) send((i % 2 == 0) ? 8'd10 : 8'd200, 1'b1);
    wait_done("fall");
    check("fall_trig_addr", trig_addr, 0);
    check("fall_trig_lane", trig_lane, 2);
    check("fall_writes", n_writes - w0, 256);
    check("fall_queue_empty", exp_q.size(), 0);

    // Rising edge inside the pretrigger fill is ignored; the next one triggers.
    w0 = n_writes;
    do_arm(8'd100, 1'b1, 8'd2, 1'b0, 8'd0);
    send(8'd0, 1'b1);
    send(8'd200, 1'b1);
    for (int i = 2; i < 31; i++) send(8'd200, 1'b1);
    send(8'd50, 1'b1);
    @(negedge clk); #1;
    check("pre_edge_ignored_lane", trig_lane, 0);
    check("pre_edge_busy", busy, 1);
    send(8'd150, 1'b1);
    @(negedge clk); #1;
    check("pre_trig_addr", trig_addr, 2);
    check("pre_trig_lane", trig_lane, 2);
    for (int i = 0; i < 5; i++) send(8'(i + 1), 1'b0);

    // Abort mid-POST with a sample on the same edge: everything back to reset values.
    abort = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample = 8'h77;
    @(posedge clk); #1;
    abort = 1'b0;
    bus.sample_valid = 1'b0;
    check_reset_outputs("abort");
    for (int i = 0; i < 20; i++) send(8'h55, 1'b0);
    check("abort_writes", n_writes - w0, 2);
    check("abort_queue_empty", exp_q.size(), 0);

    // Constant 0 never triggers; the address wraps 255 -> 0 and writes continue.
    w0 = n_writes;
    do_arm(8'd100, 1'b1, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 258 * 15; i++) send(8'd0, 1'b1);
    @(negedge clk); #1;
    check("const_writes", n_writes - w0, 258);
    check("const_busy", busy, 1);
    check("const_done", done, 0);
    check("const_last_ad", bus.ram_ad, 1);
    check("const_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a word, with a sample on the reset edge.
    for (int i = 0; i < 7; i++) send(8'd0, 1'b0);
    reset = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample = 8'h33;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.sample_valid = 1'b0;
    check_reset_outputs("midword_reset");
    w0 = n_writes;
    for (int i = 0; i < 20; i++) send(8'h44, 1'b0);
    check("reset_no_writes", n_writes - w0, 0);

    // Re-arm with a sample on the arm edge (not captured), then a 1-in-3 valid pattern.
    w0 = n_writes;
    do_arm(8'd0, 1'b1, 8'd0, 1'b1, 8'hEE);
    for (int i = 0; i < 30; i++) begin
      send(8'(8'h30 + i), 1'b1);
      repeat (2) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk); #1;
    check("gap_writes", n_writes - w0, 2);
    check("gap_queue_empty", exp_q.size(), 0);
    check("gap_busy", busy, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
